// File: rtl/super_execute.sv
// Integer execute stage feeding the EX/MEM pipeline register.
// Single-cycle ALU ops plus an iterative shift-add multiplier that stalls decode.
module super_execute #(
  parameter int REGI_BITS = 4,
  parameter int REGI_SIZE = 16,
  parameter int OP_BITS   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic [OP_BITS-1:0]   alu_op_i,
  input  logic [REGI_SIZE-1:0] opa_i,
  input  logic [REGI_SIZE-1:0] opb_i,
  input  logic [REGI_SIZE-1:0] std_i,
  input  logic [REGI_BITS-1:0] rd_i,
  input  logic                 enableReg_i,
  input  logic                 enableJump_i,
  input  logic                 flagMemRead_i,
  input  logic                 flagMemWrite_i,
  input  logic                 flush_i,
  output logic                 stall_o,
  output logic [REGI_SIZE-1:0] int_a_o,
  output logic [REGI_SIZE-1:0] int_wd_o,
  output logic [REGI_BITS-1:0] rd_o,
  output logic                 enableReg_o,
  output logic                 enableJump_o,
  output logic                 flagMemRead_o,
  output logic                 flagMemWrite_o
);

  localparam int CNT_W = $clog2(REGI_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REGI_SIZE - 1);

  localparam logic [OP_BITS-1:0] OP_ADD = OP_BITS'(0);
  localparam logic [OP_BITS-1:0] OP_SUB = OP_BITS'(1);
  localparam logic [OP_BITS-1:0] OP_AND = OP_BITS'(2);
  localparam logic [OP_BITS-1:0] OP_OR  = OP_BITS'(3);
  localparam logic [OP_BITS-1:0] OP_XOR = OP_BITS'(4);
  localparam logic [OP_BITS-1:0] OP_SLL = OP_BITS'(5);
  localparam logic [OP_BITS-1:0] OP_SRL = OP_BITS'(6);
  localparam logic [OP_BITS-1:0] OP_MUL = OP_BITS'(8);

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  function automatic logic [REGI_SIZE-1:0] alu_f(
    input logic [OP_BITS-1:0]   op,
    input logic [REGI_SIZE-1:0] a,
    input logic [REGI_SIZE-1:0] b
  );
    logic [CNT_W-1:0] sh;
    sh = b[CNT_W-1:0];
    case (op)
      OP_ADD:  alu_f = a + b;
      OP_SUB:  alu_f = a - b;
      OP_AND:  alu_f = a & b;
      OP_OR:   alu_f = a | b;
      OP_XOR:  alu_f = a ^ b;
      OP_SLL:  alu_f = a << sh;
      OP_SRL:  alu_f = a >> sh;
      default: alu_f = b;
    endcase
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [REGI_SIZE-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [REGI_SIZE-1:0] l_std_q, l_std_d;
  logic [REGI_BITS-1:0] l_rd_q, l_rd_d;
  logic                 l_en_reg_q, l_en_reg_d, l_jump_q, l_jump_d;
  logic                 l_mrd_q, l_mrd_d, l_mwr_q, l_mwr_d;
  logic [REGI_SIZE-1:0] int_a_q, int_a_d, int_wd_q, int_wd_d;
  logic [REGI_BITS-1:0] rd_q, rd_d;
  logic                 en_reg_q, en_reg_d, jump_q, jump_d, mrd_q, mrd_d, mwr_q, mwr_d;
  logic [REGI_SIZE-1:0] partial_s, acc_sum_s;

  // Shift-add step: partial product for the current multiplier bit.
  always_comb begin
    if (mplier_q[cnt_q]) begin
      partial_s = mcand_q << cnt_q;
    end else begin
      partial_s = {REGI_SIZE{1'b0}};
    end
    acc_sum_s = acc_q + partial_s;
  end

  // Next-state logic; enables and flags default to a bubble, data outputs hold.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    l_std_d    = l_std_q;
    l_rd_d     = l_rd_q;
    l_en_reg_d = l_en_reg_q;
    l_jump_d   = l_jump_q;
    l_mrd_d    = l_mrd_q;
    l_mwr_d    = l_mwr_q;
    int_a_d    = int_a_q;
    int_wd_d   = int_wd_q;
    rd_d       = rd_q;
    en_reg_d   = 1'b0;
    jump_d     = 1'b0;
    mrd_d      = 1'b0;
    mwr_d      = 1'b0;
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end else if (state_q == S_MUL) begin
      acc_d = acc_sum_s;
      if (cnt_q == CNT_LAST) begin
        state_d  = S_IDLE;
        cnt_d    = {CNT_W{1'b0}};
        int_a_d  = acc_sum_s;
        int_wd_d = l_std_q;
        rd_d     = l_rd_q;
        en_reg_d = l_en_reg_q;
        jump_d   = l_jump_q;
        mrd_d    = l_mrd_q;
        mwr_d    = l_mwr_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (valid_i) begin
      if (alu_op_i == OP_MUL) begin
        state_d    = S_MUL;
        cnt_d      = {CNT_W{1'b0}};
        acc_d      = {REGI_SIZE{1'b0}};
        mcand_d    = opa_i;
        mplier_d   = opb_i;
        l_std_d    = std_i;
        l_rd_d     = rd_i;
        l_en_reg_d = enableReg_i;
        l_jump_d   = enableJump_i & (opa_i == opb_i);
        l_mrd_d    = flagMemRead_i;
        l_mwr_d    = flagMemWrite_i;
      end else begin
        int_a_d  = alu_f(alu_op_i, opa_i, opb_i);
        int_wd_d = std_i;
        rd_d     = rd_i;
        en_reg_d = enableReg_i;
        jump_d   = enableJump_i & (opa_i == opb_i);
        mrd_d    = flagMemRead_i;
        mwr_d    = flagMemWrite_i;
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  // Pipeline, FSM and multiplier registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      mcand_q    <= {REGI_SIZE{1'b0}};
      mplier_q   <= {REGI_SIZE{1'b0}};
      acc_q      <= {REGI_SIZE{1'b0}};
      l_std_q    <= {REGI_SIZE{1'b0}};
      l_rd_q     <= {REGI_BITS{1'b0}};
      l_en_reg_q <= 1'b0;
      l_jump_q   <= 1'b0;
      l_mrd_q    <= 1'b0;
      l_mwr_q    <= 1'b0;
      int_a_q    <= {REGI_SIZE{1'b0}};
      int_wd_q   <= {REGI_SIZE{1'b0}};
      rd_q       <= {REGI_BITS{1'b0}};
      en_reg_q   <= 1'b0;
      jump_q     <= 1'b0;
      mrd_q      <= 1'b0;
      mwr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      l_std_q    <= l_std_d;
      l_rd_q     <= l_rd_d;
      l_en_reg_q <= l_en_reg_d;
      l_jump_q   <= l_jump_d;
      l_mrd_q    <= l_mrd_d;
      l_mwr_q    <= l_mwr_d;
      int_a_q    <= int_a_d;
      int_wd_q   <= int_wd_d;
      rd_q       <= rd_d;
      en_reg_q   <= en_reg_d;
      jump_q     <= jump_d;
      mrd_q      <= mrd_d;
      mwr_q      <= mwr_d;
    end
  end

  assign stall_o        = (state_q == S_MUL);
  assign int_a_o        = int_a_q;
  assign int_wd_o       = int_wd_q;
  assign rd_o           = rd_q;
  assign enableReg_o    = en_reg_q;
  assign enableJump_o   = jump_q;
  assign flagMemRead_o  = mrd_q;
  assign flagMemWrite_o = mwr_q;

endmodule

// File: tb/tb_super_execute.sv
// Directed bench for super_execute: vector table for single-cycle ops plus
// hand-written MUL, flush and reset sequences.
module tb_super_execute;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, enableReg_i, enableJump_i, flagMemRead_i, flagMemWrite_i, flush_i;
  logic [3:0]  alu_op_i, rd_i;
  logic [15:0] opa_i, opb_i, std_i;
  logic        stall_o, enableReg_o, enableJump_o, flagMemRead_o, flagMemWrite_o;
  logic [15:0] int_a_o, int_wd_o;
  logic [3:0]  rd_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  int stall_seen;

  super_execute dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .alu_op_i(alu_op_i),
    .opa_i(opa_i), .opb_i(opb_i), .std_i(std_i), .rd_i(rd_i),
    .enableReg_i(enableReg_i), .enableJump_i(enableJump_i),
    .flagMemRead_i(flagMemRead_i), .flagMemWrite_i(flagMemWrite_i),
    .flush_i(flush_i), .stall_o(stall_o), .int_a_o(int_a_o), .int_wd_o(int_wd_o),
    .rd_o(rd_o), .enableReg_o(enableReg_o), .enableJump_o(enableJump_o),
    .flagMemRead_o(flagMemRead_o), .flagMemWrite_o(flagMemWrite_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b, std;
    logic [3:0]  rd;
    logic        en_reg, en_jump, mrd, mwr;
    logic [15:0] exp_a;
    logic        exp_jump;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] sd, input logic [3:0] rd, input logic er,
                       input logic ej, input logic mr, input logic mw);
    valid_i = 1'b1; alu_op_i = op; opa_i = a; opb_i = b; std_i = sd; rd_i = rd;
    enableReg_i = er; enableJump_i = ej; flagMemRead_i = mr; flagMemWrite_i = mw;
  endtask

  task automatic idle_in();
    valid_i = 1'b0; alu_op_i = 4'd0; opa_i = 16'h0; opb_i = 16'h0; std_i = 16'h0;
    rd_i = 4'd0; enableReg_i = 1'b0; enableJump_i = 1'b0;
    flagMemRead_i = 1'b0; flagMemWrite_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_bubble(input string name);
    chk({name, "_en_reg"}, {31'd0, enableReg_o}, 32'd0);
    chk({name, "_jump"}, {31'd0, enableJump_o}, 32'd0);
    chk({name, "_mrd"}, {31'd0, flagMemRead_o}, 32'd0);
    chk({name, "_mwr"}, {31'd0, flagMemWrite_o}, 32'd0);
  endtask

  initial begin
    //          op     a         b         std       rd    er    ej    mr    mw    exp_a     exp_j
    vecs[0]  = '{4'd0, 16'hFFFF, 16'h0001, 16'h1111, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{4'd1, 16'h0000, 16'h0001, 16'h2222, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0};
    vecs[2]  = '{4'd5, 16'h0001, 16'h000F, 16'h3333, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0};
    vecs[3]  = '{4'd6, 16'h8000, 16'h000F, 16'h4444, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0};
    vecs[4]  = '{4'd2, 16'hF0F0, 16'h0FF0, 16'h0000, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00F0, 1'b0};
    vecs[5]  = '{4'd3, 16'hF000, 16'h000F, 16'h0000, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 16'hF00F, 1'b0};
    vecs[6]  = '{4'd4, 16'hFFFF, 16'h0F0F, 16'h0000, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 16'hF0F0, 1'b0};
    vecs[7]  = '{4'd7, 16'h5555, 16'h1234, 16'h0000, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0};
    vecs[8]  = '{4'd15, 16'h0001, 16'hABCD, 16'h0000, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 16'hABCD, 1'b0};
    vecs[9]  = '{4'd0, 16'h0010, 16'h0004, 16'hBEEF, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0014, 1'b0};
    vecs[10] = '{4'd0, 16'h0005, 16'h0005, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h000A, 1'b1};
    vecs[11] = '{4'd0, 16'h0005, 16'h0006, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h000B, 1'b0};
    vecs[12] = '{4'd0, 16'h0100, 16'h0002, 16'h0000, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0102, 1'b0};

    rst_i = 1'b0; flush_i = 1'b0; idle_in();
    tick(); tick();
    chk("rst_int_a", {16'd0, int_a_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk_bubble("rst");
    @(negedge clk_i); rst_i = 1'b1;

    // Back-to-back single-cycle ops, no stall expected.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].std, vecs[i].rd,
            vecs[i].en_reg, vecs[i].en_jump, vecs[i].mrd, vecs[i].mwr);
      tick();
      chk($sformatf("v%0d_int_a", i), {16'd0, int_a_o}, {16'd0, vecs[i].exp_a});
      chk($sformatf("v%0d_wd", i), {16'd0, int_wd_o}, {16'd0, vecs[i].std});
      chk($sformatf("v%0d_rd", i), {28'd0, rd_o}, {28'd0, vecs[i].rd});
      chk($sformatf("v%0d_en_reg", i), {31'd0, enableReg_o}, {31'd0, vecs[i].en_reg});
      chk($sformatf("v%0d_jump", i), {31'd0, enableJump_o}, {31'd0, vecs[i].exp_jump});
      chk($sformatf("v%0d_mrd", i), {31'd0, flagMemRead_o}, {31'd0, vecs[i].mrd});
      chk($sformatf("v%0d_mwr", i), {31'd0, flagMemWrite_o}, {31'd0, vecs[i].mwr});
      chk($sformatf("v%0d_stall", i), {31'd0, stall_o}, 32'd0);
    end

    // Bubble: flags clear, data outputs hold.
    idle_in(); tick();
    chk_bubble("bub");
    chk("bub_int_a_hold", {16'd0, int_a_o}, 32'h0102);
    chk("bub_rd_hold", {28'd0, rd_o}, 32'd3);

    // MUL 0x0123*0x0010 with ADD 1+1 held behind it.
    drive(4'd8, 16'h0123, 16'h0010, 16'h1111, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    stall_seen = 0;
    if (stall_o) stall_seen++;
    chk_bubble("mul_e0");
    drive(4'd0, 16'h0001, 16'h0001, 16'h0000, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < 16; k++) begin
      tick();
      if (stall_o) stall_seen++;
      chk($sformatf("mul_e%0d_en_reg", k), {31'd0, enableReg_o}, 32'd0);
    end
    tick();
    if (stall_o) stall_seen++;
    chk("mul_stall_cycles", stall_seen, 32'd16);
    chk("mul_result", {16'd0, int_a_o}, 32'h1230);
    chk("mul_en_reg", {31'd0, enableReg_o}, 32'd1);
    chk("mul_rd", {28'd0, rd_o}, 32'd5);
    chk("mul_wd", {16'd0, int_wd_o}, 32'h1111);
    tick();
    chk("post_mul_add", {16'd0, int_a_o}, 32'd2);
    chk("post_mul_rd", {28'd0, rd_o}, 32'd6);
    chk("post_mul_stall", {31'd0, stall_o}, 32'd0);

    // Flush at cnt=9 of MUL 0xFFFF*0xFFFF.
    drive(4'd8, 16'hFFFF, 16'hFFFF, 16'h0000, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    idle_in();
    for (int k = 1; k <= 9; k++) tick();
    chk("fl_stall_before", {31'd0, stall_o}, 32'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fl_stall_after", {31'd0, stall_o}, 32'd0);
    chk_bubble("fl");
    chk("fl_int_a_hold", {16'd0, int_a_o}, 32'd2);
    drive(4'd0, 16'h0002, 16'h0002, 16'h0000, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fl_next_add", {16'd0, int_a_o}, 32'd4);
    chk("fl_next_en", {31'd0, enableReg_o}, 32'd1);
    idle_in();
    for (int k = 0; k < 18; k++) tick();
    chk("fl_no_late_result", {16'd0, int_a_o}, 32'd4);
    chk_bubble("fl_late");

    // Flush coinciding with the MUL final edge discards the result.
    drive(4'd8, 16'h0003, 16'h0003, 16'h0000, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle_in();
    for (int k = 1; k <= 15; k++) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flfin_int_a", {16'd0, int_a_o}, 32'd4);
    chk("flfin_stall", {31'd0, stall_o}, 32'd0);
    chk_bubble("flfin");

    // Asynchronous reset mid-MUL at cnt=7.
    drive(4'd8, 16'h0007, 16'h0009, 16'h0000, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle_in();
    for (int k = 1; k <= 7; k++) tick();
    chk("ar_stall_before", {31'd0, stall_o}, 32'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("ar_stall", {31'd0, stall_o}, 32'd0);
    chk("ar_int_a", {16'd0, int_a_o}, 32'd0);
    chk("ar_rd", {28'd0, rd_o}, 32'd0);
    chk_bubble("ar");
    @(negedge clk_i); rst_i = 1'b1;
    drive(4'd0, 16'h0003, 16'h0004, 16'h0000, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("ar_add", {16'd0, int_a_o}, 32'd7);
    chk("ar_add_stall", {31'd0, stall_o}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/super_execute.md
Name: super_execute

Overview:
- Integer execute stage directly upstream of the memory stage; drives its address, write-data, memory-flag and enable inputs through an EX/MEM pipeline register.
- Single-cycle ALU ops complete in one clock. MUL runs on an iterative shift-add unit over REGI_SIZE cycles and stalls the decode stage while busy.
- Vector lanes are out of scope for this block.

Parameters:
REGI_BITS, 4, register index width
REGI_SIZE, 16, integer datapath width
OP_BITS, 4, ALU opcode width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
valid_i  in  1  decode presents an instruction
alu_op_i  in  OP_BITS  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 PASSB, 8 MUL; others behave as PASSB
opa_i  in  REGI_SIZE  operand A
opb_i  in  REGI_SIZE  operand B, register or immediate as muxed by decode
std_i  in  REGI_SIZE  store data
rd_i  in  REGI_BITS  destination register index
enableReg_i  in  1  instruction writes the register file
enableJump_i  in  1  conditional jump: taken when opa_i == opb_i
flagMemRead_i  in  1  load
flagMemWrite_i  in  1  store
flush_i  in  1  squash the in-flight instruction
stall_o  out  1  decode must hold its inputs
int_a_o  out  REGI_SIZE  ALU result / memory address
int_wd_o  out  REGI_SIZE  registered std_i
rd_o  out  REGI_BITS  registered rd_i
enableReg_o  out  1  registered enableReg_i
enableJump_o  out  1  registered jump-taken
flagMemRead_o  out  1  registered load flag
flagMemWrite_o  out  1  registered store flag

Behaviour:
- Reset (rst_i low, asynchronous): all outputs 0, FSM in IDLE, MUL counter 0, stall_o 0.
- Bubble: all enable and flag outputs 0. int_a_o, int_wd_o and rd_o keep their previous values.
- FSM states are IDLE and MUL. stall_o = (state == MUL), decoded from registered state.
- Accept condition: an instruction is accepted on a rising edge when state == IDLE, valid_i = 1 and flush_i = 0.
- Accepted non-MUL op: on that edge int_a_o gets the result and every other output gets its registered input. enableJump_o = enableJump_i & (opa_i == opb_i). Latency is 1 edge.
- IDLE with valid_i = 0: outputs a bubble.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^REGI_SIZE.
  - SLL/SRL are logical shifts by opb_i[log2(REGI_SIZE)-1:0].
  - MUL keeps the low REGI_SIZE bits of the product, treated as unsigned.
- Accepted MUL, acceptance edge E0:
  - Latch the operands and side-band inputs, clear the accumulator and counter, go to MUL, output a bubble.
  - Each edge in MUL: if multiplier bit[cnt] = 1, add the multiplicand shifted left by cnt to the accumulator; then cnt increments.
  - On the edge where cnt == REGI_SIZE-1, the final accumulator goes to int_a_o with the latched side-band, and the FSM returns to IDLE.
  - The result is visible after edge E0+REGI_SIZE.
  - Bubbles are output after edges E1 .. E(REGI_SIZE-1).
  - stall_o is high for exactly REGI_SIZE cycles.
- While stall_o = 1, valid_i and all other decode inputs are ignored. Decode holds its next instruction, which is accepted on the first edge with stall_o = 0.
- flush_i = 1 has highest priority. On that edge: output a bubble, abort any MUL (FSM to IDLE, counter cleared), and do not accept the input. stall_o falls the following cycle.
- Simultaneous flush_i and MUL final edge: the flush wins and the result is discarded.
- enableJump_o is a single-cycle registered pulse. Flushing younger instructions is the job of the control unit, which drives flush_i.
- A multiply by 0 still takes the full REGI_SIZE cycles; there is no early termination.

Test Plan:
- Reset with rst_i low mid-MUL (cnt = 7) -> outputs 0, stall_o 0 immediately, before the next clock edge. After release, ADD 3+4 is accepted and int_a_o = 7 one edge later.
- Back-to-back ADD 0xFFFF+1, SUB 0-1, SLL 1<<15, SRL 0x8000>>15 on consecutive cycles -> int_a_o is 0x0000, 0xFFFF, 0x8000, 0x0001 on consecutive edges; no stall.
- MUL 0x0123*0x0010 followed by ADD 1+1 held by decode:
  - stall_o high for 16 cycles.
  - int_a_o = 0x1230 with enableReg_o = 1 after E16.
  - int_a_o = 2 after E17.
- Store: ADD 0x0010+0x0004, flagMemWrite_i = 1, std_i = 0xBEEF -> int_a_o = 0x0014, int_wd_o = 0xBEEF, flagMemWrite_o = 1 for exactly one cycle.
- Jump: enableJump_i with opa = opb = 5 -> enableJump_o = 1. With opa = 5, opb = 6 -> enableJump_o = 0.
- flush_i pulsed at cnt = 9 of MUL 0xFFFF*0xFFFF -> no result emitted, stall_o 0 the next cycle, all flags 0. The next ADD 2+2 gives int_a_o = 4.
